// File: rtl/fft_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// fft_stage_ctrl_if
// Handshake bundle between the FFT stage sequencer and its environment.
//   go         : request one full transform (sampled only while idle)
//   stall      : datapath back-pressure, holds butterfly issue while high
//   start      : one-cycle pulse marking the beginning of a stage
//   stage      : current stage index for the coefficient mapper
//   bfly_valid : butterfly issue strobe
//   bfly_idx   : index of the butterfly issued this cycle
//   busy       : high whenever the sequencer is not idle
//   done       : one-cycle pulse after the final stage has drained
// master = environment side (drives go/stall), slave = sequencer side.
// -----------------------------------------------------------------------------
interface fft_stage_ctrl_if;
  logic       go;
  logic       stall;
  logic       start;
  logic [1:0] stage;
  logic       bfly_valid;
  logic [2:0] bfly_idx;
  logic       busy;
  logic       done;

  modport master (
    output go, stall,
    input  start, stage, bfly_valid, bfly_idx, busy, done
  );

  modport slave (
    input  go, stall,
    output start, stage, bfly_valid, bfly_idx, busy, done
  );
endinterface

// File: rtl/fft_stage_ctrl.sv
// -----------------------------------------------------------------------------
// fft_stage_ctrl
// Sequences one FFT transform: for each of N_STAGES stages it pulses start,
// issues N_BFLY butterflies (honouring stall), waits DRAIN_LAT cycles for the
// datapath pipeline to empty, then moves on; a done pulse closes the transform.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : fft_stage_ctrl_if.slave (go/stall in; start, stage, bfly_valid,
//         bfly_idx, busy, done out)
// All outputs are registers or decodes of the registered state, so go and
// stall never reach an output combinationally.
// -----------------------------------------------------------------------------
module fft_stage_ctrl #(
  parameter int N_STAGES  = 4,
  parameter int N_BFLY    = 8,
  parameter int DRAIN_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  fft_stage_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] LAST_STAGE = 2'(N_STAGES - 1);
  localparam logic [2:0] LAST_IDX   = 3'(N_BFLY - 1);
  localparam logic [2:0] DRAIN_LAST = (DRAIN_LAT > 0) ? 3'(DRAIN_LAT - 1) : 3'd0;

  state_t     state_q;
  logic [1:0] stage_q;
  logic       bfly_valid_q;
  logic [2:0] bfly_idx_q;
  logic [2:0] drain_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stage_q      <= '0;
      bfly_valid_q <= 1'b0;
      bfly_idx_q   <= '0;
      drain_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          stage_q <= '0;
          if (bus.go) state_q <= S_LAUNCH;
        end

        // The first butterfly of a stage always issues right after LAUNCH:
        // stall is ignored during LAUNCH, so the edge leaving it never holds.
        S_LAUNCH: begin
          state_q      <= S_ISSUE;
          bfly_valid_q <= 1'b1;
          bfly_idx_q   <= '0;
        end

        // bfly_idx_q always holds the most recently issued index here, so a
        // stall keeps it frozen and the next issue is simply idx+1.
        S_ISSUE: begin
          if (bfly_valid_q && (bfly_idx_q == LAST_IDX)) begin
            bfly_valid_q <= 1'b0;
            bfly_idx_q   <= '0;
            if (DRAIN_LAT == 0) begin
              if (stage_q == LAST_STAGE) begin
                state_q <= S_DONE;
              end else begin
                stage_q <= stage_q + 2'd1;
                state_q <= S_LAUNCH;
              end
            end else begin
              state_q     <= S_DRAIN;
              drain_cnt_q <= DRAIN_LAST;
            end
          end else if (bus.stall) begin
            bfly_valid_q <= 1'b0;
          end else begin
            bfly_valid_q <= 1'b1;
            bfly_idx_q   <= bfly_idx_q + 3'd1;
          end
        end

        S_DRAIN: begin
          if (drain_cnt_q != 3'd0) begin
            drain_cnt_q <= drain_cnt_q - 3'd1;
          end else if (stage_q == LAST_STAGE) begin
            state_q <= S_DONE;
          end else begin
            stage_q <= stage_q + 2'd1;
            state_q <= S_LAUNCH;
          end
        end

        // go seen here is deliberately dropped; a new transform needs go
        // sampled in the following IDLE cycle.
        S_DONE: begin
          state_q <= S_IDLE;
          stage_q <= '0;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.start      = (state_q == S_LAUNCH);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.stage      = stage_q;
  assign bus.bfly_valid = bfly_valid_q;
  assign bus.bfly_idx   = bfly_idx_q;

endmodule
